// File: rtl/noc_pkg.sv
// Shared definitions for the PGNoC switch output stage: flit layout, channel states, sizing helpers.
// Flit layout (LSB first): destination address, payload, tail bit.
package noc_pkg;

    localparam int ADDR_LSB = 0;

    function automatic int payload_lsb(input int addr_size);
        return addr_size;
    endfunction

    function automatic int tail_bit(input int data_size, input int addr_size);
        return data_size + addr_size;
    endfunction

    function automatic int bus_size(input int data_size, input int addr_size);
        return data_size + addr_size + 1;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_HOLD = 1'b1
    } ch_state_t;

endpackage

// File: rtl/routing_module.sv
// XY routing on a square 2D mesh. Ports: 0=x+, 1=x-, 2=y+, 3=y-, PORTS_NUM=local.
// Destinations outside the node range are delivered locally.
module routing_module
    import noc_pkg::*;
#(
    parameter int ADDR      = 0,
    parameter int ADDR_SIZE = 4,
    parameter int PORTS_NUM = 4,
    parameter int NODES_NUM = 9,
    localparam int PSEL     = clog2(PORTS_NUM + 1)
) (
    input  logic [ADDR_SIZE-1:0] dest,
    output logic [PSEL-1:0]      port
);

    function automatic int mesh_side(input int n);
        int s;
        s = 1;
        while (s * s < n) s++;
        return s;
    endfunction

    localparam int SIDE   = mesh_side(NODES_NUM);
    localparam int SELF_X = ADDR % SIDE;
    localparam int SELF_Y = ADDR / SIDE;

    always_comb begin
        int dx;
        int dy;
        dx   = int'(dest) % SIDE;
        dy   = int'(dest) / SIDE;
        port = PSEL'(PORTS_NUM);
        if (int'(dest) >= NODES_NUM) port = PSEL'(PORTS_NUM);
        else if (dx > SELF_X)        port = PSEL'(0);
        else if (dx < SELF_X)        port = PSEL'(1);
        else if (dy > SELF_Y)        port = PSEL'(2);
        else if (dy < SELF_Y)        port = PSEL'(3);
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer;
// the pointer moves past the winner only when a grant is issued.
module rr_arbiter
    import noc_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         a_rst,
    input  logic [N-1:0] request,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic          found;

    always_comb begin
        int idx;
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && request[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (a_rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
        end
    end

endmodule

// File: rtl/multi_queue_transceiver.sv
// Switch output stage: routes the head flit of each input queue and grants one queue per cycle
// onto an idle output channel; channels hold the flit until the downstream acknowledges it.
//
// channel state | meaning
// CH_IDLE       | no flit pending, wr_ready_out low, may accept a grant
// CH_HOLD       | flit presented on data_o, wr_ready_out high, waiting for r_ready_in
module multi_queue_transceiver
    import noc_pkg::*;
#(
    parameter int ADDR       = 0,
    parameter int DATA_SIZE  = 32,
    parameter int ADDR_SIZE  = 4,
    parameter int PORTS_NUM  = 4,
    parameter int NODES_NUM  = 9,
    parameter int QUEUES_NUM = 2,
    parameter logic [PORTS_NUM-1:0] CONN_MASK = '1,
    parameter int CNT_SIZE   = 16,
    localparam int BUS_SIZE  = bus_size(DATA_SIZE, ADDR_SIZE)
) (
    input  logic                               clk,
    input  logic                               a_rst,
    input  logic [QUEUES_NUM-1:0]              mem_empty,
    input  logic [BUS_SIZE*QUEUES_NUM-1:0]     data_i,
    input  logic [PORTS_NUM:0]                 r_ready_in,
    output logic [QUEUES_NUM-1:0]              readed,
    output logic [PORTS_NUM:0]                 wr_ready_out,
    output logic [BUS_SIZE*(PORTS_NUM+1)-1:0]  data_o,
    output logic [CNT_SIZE-1:0]                flits_sent
);

    localparam int CH_NUM = PORTS_NUM + 1;
    localparam int PSEL   = clog2(CH_NUM);
    localparam int QW     = (QUEUES_NUM > 1) ? clog2(QUEUES_NUM) : 1;
    localparam int RCW    = clog2(CH_NUM + 1);
    localparam int SW     = CNT_SIZE + RCW;
    // The local port is always present, so it is treated as connected.
    localparam logic [CH_NUM-1:0] CONN_EXT = {1'b1, CONN_MASK};

    logic [PSEL-1:0]       route_raw  [QUEUES_NUM];
    logic [PSEL-1:0]       route_port [QUEUES_NUM];
    logic [QUEUES_NUM-1:0] request;
    logic [QUEUES_NUM-1:0] grant;
    logic [QW-1:0]         gnt_q;
    logic [PSEL-1:0]       gnt_port;
    logic                  gnt_any;
    ch_state_t             state     [CH_NUM];
    ch_state_t             state_nxt [CH_NUM];
    logic [CH_NUM-1:0]     release_ch;
    logic [RCW-1:0]        rel_cnt;
    logic [SW-1:0]         cnt_sum;
    logic [BUS_SIZE-1:0]   data_r    [CH_NUM];

    for (genvar q = 0; q < QUEUES_NUM; q++) begin : g_queue
        routing_module #(
            .ADDR      (ADDR),
            .ADDR_SIZE (ADDR_SIZE),
            .PORTS_NUM (PORTS_NUM),
            .NODES_NUM (NODES_NUM)
        ) u_route (
            .dest (data_i[q*BUS_SIZE + ADDR_LSB +: ADDR_SIZE]),
            .port (route_raw[q])
        );
        // Flits for an unconnected port loop back to the local node.
        assign route_port[q] = (route_raw[q] < PSEL'(PORTS_NUM) && !CONN_EXT[route_raw[q]])
                             ? PSEL'(PORTS_NUM) : route_raw[q];
    end

    // A queue popped last cycle still shows its old head, so it sits out one cycle.
    always_comb begin
        request = '0;
        for (int q = 0; q < QUEUES_NUM; q++) begin
            request[q] = !mem_empty[q] && !readed[q] && (state[route_port[q]] == CH_IDLE);
        end
    end

    rr_arbiter #(
        .N (QUEUES_NUM)
    ) u_arb (
        .clk     (clk),
        .a_rst   (a_rst),
        .request (request),
        .grant   (grant)
    );

    always_comb begin
        gnt_any  = |grant;
        gnt_q    = '0;
        gnt_port = '0;
        for (int q = 0; q < QUEUES_NUM; q++) begin
            if (grant[q]) begin
                gnt_q    = QW'(q);
                gnt_port = route_port[q];
            end
        end
    end

    always_comb begin
        for (int p = 0; p < CH_NUM; p++) begin
            state_nxt[p]  = state[p];
            release_ch[p] = 1'b0;
            case (state[p])
                CH_IDLE: begin
                    if (gnt_any && gnt_port == PSEL'(p)) state_nxt[p] = CH_HOLD;
                end
                CH_HOLD: begin
                    if (r_ready_in[p]) begin
                        state_nxt[p]  = CH_IDLE;
                        release_ch[p] = 1'b1;
                    end
                end
                default: state_nxt[p] = CH_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < CH_NUM; p++) begin
            state[p] <= a_rst ? CH_IDLE : state_nxt[p];
        end
    end

    always_comb begin
        rel_cnt = '0;
        for (int p = 0; p < CH_NUM; p++) rel_cnt = rel_cnt + RCW'(release_ch[p]);
    end

    assign cnt_sum = SW'(flits_sent) + SW'(rel_cnt);

    always_ff @(posedge clk) begin
        if (a_rst) begin
            readed     <= '0;
            flits_sent <= '0;
            for (int p = 0; p < CH_NUM; p++) data_r[p] <= '0;
        end else begin
            readed <= grant;
            if (gnt_any) data_r[gnt_port] <= data_i[int'(gnt_q)*BUS_SIZE +: BUS_SIZE];
            flits_sent <= (|cnt_sum[SW-1:CNT_SIZE]) ? '1 : cnt_sum[CNT_SIZE-1:0];
        end
    end

    for (genvar p = 0; p < CH_NUM; p++) begin : g_out
        assign wr_ready_out[p]                 = (state[p] == CH_HOLD);
        assign data_o[p*BUS_SIZE +: BUS_SIZE] = data_r[p];
    end

endmodule

// File: doc/multi_queue_transceiver.md
Name: multi_queue_transceiver

Overview:
- Output stage of a PGNoC switch, parametrised successor of the single-queue transceiver.
- Serves QUEUES_NUM input queues (one per input port or virtual channel) onto PORTS_NUM+1 output channels; the highest index is the local/loop-back port.
- Each head flit is routed by routing_module.
- A round-robin arbiter grants one queue per cycle to a free output channel, so flits to different ports are in flight concurrently and head-of-line blocking across queues is avoided.
- Unconnected ports are declared by parameter mask, not detected through 'z'.

Parameters:
- ADDR, 0, this switch's node address (passed to routing_module)
- DATA_SIZE, 32, payload bits per flit
- ADDR_SIZE, 4, destination-address bits; these are flit bits [ADDR_SIZE-1:0]
- PORTS_NUM, 4, number of network ports; port PORTS_NUM is local
- NODES_NUM, 9, node count (passed to routing_module)
- QUEUES_NUM, 2, number of input queues served
- CONN_MASK, all ones (PORTS_NUM bits), bit p=1 means network port p is connected
- CNT_SIZE, 16, width of the sent-flit counter
- BUS_SIZE (localparam), DATA_SIZE+ADDR_SIZE+1, flit width

Ports:
- clk  in  1  clock, all logic on rising edge
- a_rst  in  1  reset, synchronous, active-high (name kept for codebase consistency)
- mem_empty  in  QUEUES_NUM  per-queue empty flag
- data_i  in  BUS_SIZE*QUEUES_NUM  head flit of each queue, valid while mem_empty[q]=0
- r_ready_in  in  PORTS_NUM+1  per-port downstream acknowledge (level)
- readed  out  QUEUES_NUM  one-cycle pop pulse per queue
- wr_ready_out  out  PORTS_NUM+1  per-port flit-valid
- data_o  out  BUS_SIZE*(PORTS_NUM+1)  per-port flit
- flits_sent  out  CNT_SIZE  count of acknowledged flits, saturating

Behaviour:
- Reset:
  - Applied at a clock edge with a_rst=1; overrides everything.
  - readed=0, wr_ready_out=0, data_o=0, flits_sent=0.
  - All channels go IDLE; RR pointer=0.
  - Reset during HOLD discards the held flit. It was already popped and is lost by design.
- Routing:
  - Port pq is the routing_module output (one instance per queue) for data_i[q] address bits.
  - If pq<PORTS_NUM and CONN_MASK[pq]=0, the flit is sent to port PORTS_NUM, returning it to the local node.
- Queue eligibility in a cycle:
  - mem_empty[q]=0, AND
  - readed[q]=0 (the head is stale in the pop cycle), AND
  - target port channel IDLE (wr_ready_out[pq]=0).
- Arbitration:
  - At most one grant per cycle.
  - Round-robin over eligible queues, starting at the RR pointer.
  - On grant to q, the pointer becomes (q+1) mod QUEUES_NUM; otherwise it is unchanged.
- Grant at edge t (registered outputs visible after t):
  - data_o[pq] <= data_i[q]
  - wr_ready_out[pq] <= 1
  - readed[q] <= 1 for exactly one cycle
  - Channel pq enters HOLD.
  - Latency: mem_empty[q] falls before edge t → wr_ready_out high after edge t (1 cycle).
- Per-channel FSM:
  - IDLE → HOLD on grant.
  - HOLD → IDLE at the first edge with r_ready_in[p]=1. At that edge wr_ready_out[p] <= 0 and flits_sent increments, saturating at all-ones.
  - data_o[p] retains its last value after release.
- No release and grant on the same channel at the same edge. The minimum back-to-back spacing per port is 2 cycles between wr_ready_out rising edges (high, then one cycle low).
- Simultaneous events:
  - Releases on several ports at one edge are all honoured; flits_sent adds the number of releases, saturating.
  - One grant may coincide with releases on other ports.
- A queue blocked on a busy port does not block other queues.
- r_ready_in on an IDLE channel is ignored.
- data_i of a queue is sampled only at its grant edge.

Decomposition:
- Package noc_pkg:
  - flit field offsets (address LSBs, payload, tail bit)
  - BUS_SIZE function
  - channel-state encoding (IDLE/HOLD)
  - clog2 helper
- Sub-module rr_arbiter:
  - parameter N
  - request vector in, one-hot grant out, pointer register inside, advance-on-grant
  - synchronous reset on a_rst
- routing_module is reused unchanged.

Test Plan:
- Reset, then idle 5 cycles → all outputs 0, flits_sent=0. Assert a_rst while port 0 is in HOLD → wr_ready_out=0 next cycle, flits_sent unchanged.
- Queue 0 non-empty, flit dest routes to port 0, CONN_MASK=4'b1111, r_ready_in[0] pulsed 3 cycles after wr_ready_out[0] rises → readed[0] one cycle, data_o[0]=data_i[0], wr_ready_out[0] drops the edge after the ack, flits_sent=1.
- Same flit with CONN_MASK=4'b1110 → flit appears on port 4 (local), port 0 untouched.
- Both queues target port 2 continuously, ack held high → grants alternate q0,q1,q0,q1. wr_ready_out[2] high one cycle, low one cycle, repeating.
- q0 targets busy port 1 (never acked); q1 targets port 3 → q1 granted every other cycle while q0 stalls. readed[0] stays 0.
- CNT_SIZE=2, 5 acked flits → flits_sent sequence 1,2,3,3,3 (saturates).
